// File: rtl/qeciphy_rx_word_aligner.sv
// -----------------------------------------------------------------------------
// qeciphy_rx_word_aligner
//
// RX gearbox and word aligner on the fast RX clock. It collects RATIO narrow
// byte-aligned words into one wide word. It finds the wide-word boundary by
// spotting a periodic frame-alignment word (FAW). The FAW is confirmed
// LOCK_COUNT times before lock is declared. Lock is dropped after UNLOCK_COUNT
// consecutive misses at the scheduled FAW slot.
//
// Handshake: tvalid_i=1 means tdata_i is taken this cycle. There is no ready
// and no backpressure. tvalid_o is a one-cycle strobe, and tdata_o holds its
// value until the next strobe. A strobe is only issued while aligned_o=1.
//
// Ports
//   clk_i        in   1                RX fast clock, rising edge
//   rst_i        in   1                synchronous active-high reset
//   tdata_i      in   IN_WIDTH         byte-aligned input word
//   tvalid_i     in   1                input word accepted this cycle
//   tdata_o      out  IN_WIDTH*RATIO   assembled word, first-received in LSBs
//   tvalid_o     out  1                output strobe (only while aligned)
//   aligned_o    out  1                block is in LOCKED
//   phase_o      out  max(1,clog2(R))  input index (mod RATIO) ending a word
//   align_err_o  out  1                pulse on LOCKED -> SEARCH
// -----------------------------------------------------------------------------
module qeciphy_rx_word_aligner #(
  parameter int IN_WIDTH     = 32,
  parameter int RATIO        = 2,
  parameter logic [IN_WIDTH*RATIO-1:0] FAW_PATTERN = 64'hBCBC_BCBC_F0F0_F0F0,
  parameter logic [IN_WIDTH*RATIO-1:0] FAW_MASK    = '1,
  parameter int FAW_PERIOD   = 128,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  localparam int OUT_WIDTH   = IN_WIDTH * RATIO,
  localparam int PHASE_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  tdata_i,
  input  logic                 tvalid_i,
  output logic [OUT_WIDTH-1:0] tdata_o,
  output logic                 tvalid_o,
  output logic                 aligned_o,
  output logic [PHASE_W-1:0]   phase_o,
  output logic                 align_err_o
);

  localparam int FILL_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int WCNT_W = $clog2(FAW_PERIOD);
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int HIST_W = IN_WIDTH * (RATIO - 1);

  localparam logic [PHASE_W-1:0] IDX_LAST    = PHASE_W'(RATIO - 1);
  localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(RATIO - 1);
  localparam logic [WCNT_W-1:0]  WCNT_LAST   = WCNT_W'(FAW_PERIOD - 1);
  localparam logic [HIT_W-1:0]   HIT_LOCK    = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  MISS_UNLOCK = MISS_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Only the newest RATIO-1 accepted words are stored. The candidate window
  // is these plus the word arriving now. As a result, the match and the output
  // word for an accept are both formed in the same cycle as that accept.
  logic [HIST_W-1:0]    hist_q;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [PHASE_W-1:0]   in_idx_q, in_idx_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [OUT_WIDTH-1:0] window;
  logic                 window_full;
  logic                 match;
  logic                 boundary;
  logic                 faw_slot;
  logic                 emit;
  logic                 err;

  // Oldest word ends up in the LSBs; the arriving word is the MSB slice.
  assign window      = {tdata_i, hist_q};
  // True when this accept is at least the RATIO-th since the window was cleared.
  assign window_full = (fill_q == FILL_LAST);
  assign match       = ((window & FAW_MASK) == (FAW_PATTERN & FAW_MASK));
  assign boundary    = tvalid_i && (in_idx_q == phase_q);
  // At this boundary word_cnt wraps to 0, so the word is a scheduled FAW slot.
  assign faw_slot    = boundary && (word_cnt_q == WCNT_LAST);

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    in_idx_d   = in_idx_q;
    phase_d    = phase_q;
    word_cnt_d = word_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    emit       = 1'b0;
    err        = 1'b0;

    if (tvalid_i) begin
      if (fill_q != FILL_LAST) begin
        fill_d = fill_q + FILL_W'(1);
      end
      in_idx_d = (in_idx_q == IDX_LAST) ? '0 : in_idx_q + PHASE_W'(1);
    end

    // Outside SEARCH, word_cnt advances at every boundary.
    if (boundary && (state_q != ST_SEARCH)) begin
      word_cnt_d = (word_cnt_q == WCNT_LAST) ? '0 : word_cnt_q + WCNT_W'(1);
    end

    case (state_q)
      ST_SEARCH: begin
        if (tvalid_i && window_full && match) begin
          phase_d    = in_idx_q;
          word_cnt_d = '0;
          hit_cnt_d  = HIT_W'(1);
          miss_cnt_d = '0;
          if (LOCK_COUNT == 1) begin
            state_d = ST_LOCKED;
            // The FAW that completes the lock is itself output.
            emit    = 1'b1;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end

      ST_VERIFY: begin
        // Matches at any point other than the scheduled slot are ignored.
        if (faw_slot) begin
          if (match) begin
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
            if (hit_cnt_q + HIT_W'(1) == HIT_LOCK) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
              emit       = 1'b1;
            end
          end else begin
            state_d    = ST_SEARCH;
            fill_d     = '0;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            word_cnt_d = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (faw_slot) begin
            if (match) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + MISS_W'(1) == MISS_UNLOCK) begin
              // The word at the failing slot is dropped, not output.
              state_d    = ST_SEARCH;
              emit       = 1'b0;
              err        = 1'b1;
              fill_d     = '0;
              hit_cnt_d  = '0;
              miss_cnt_d = '0;
              word_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      in_idx_q    <= '0;
      phase_q     <= '0;
      word_cnt_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      tdata_o     <= '0;
      tvalid_o    <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      in_idx_q    <= in_idx_d;
      phase_q     <= phase_d;
      word_cnt_q  <= word_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      tvalid_o    <= emit;
      align_err_o <= err;
      if (tvalid_i) begin
        hist_q <= window[OUT_WIDTH-1:IN_WIDTH];
      end
      if (emit) begin
        tdata_o <= window;
      end
    end
  end

  assign aligned_o = (state_q == ST_LOCKED);
  assign phase_o   = phase_q;

endmodule

// File: tb/tb_qeciphy_rx_word_aligner.sv
module tb_qeciphy_rx_word_aligner;

  localparam logic [63:0] FAW = 64'hBCBC_BCBC_F0F0_F0F0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // RATIO=2, IN_WIDTH=32 instance
  logic [31:0] d2_in;
  logic        d2_v;
  logic [63:0] d2_out;
  logic        d2_vo, d2_al, d2_err;
  logic [0:0]  d2_ph;

  // RATIO=4, IN_WIDTH=16 instance
  logic [15:0] d4_in;
  logic        d4_v;
  logic [63:0] d4_out;
  logic        d4_vo, d4_al, d4_err;
  logic [1:0]  d4_ph;

  qeciphy_rx_word_aligner #(.IN_WIDTH(32), .RATIO(2), .FAW_PATTERN(FAW),
    .FAW_PERIOD(128), .LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .tdata_i(d2_in), .tvalid_i(d2_v),
    .tdata_o(d2_out), .tvalid_o(d2_vo), .aligned_o(d2_al),
    .phase_o(d2_ph), .align_err_o(d2_err));

  qeciphy_rx_word_aligner #(.IN_WIDTH(16), .RATIO(4), .FAW_PATTERN(FAW),
    .FAW_PERIOD(128), .LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut4 (
    .clk_i(clk), .rst_i(rst), .tdata_i(d4_in), .tvalid_i(d4_v),
    .tdata_o(d4_out), .tvalid_o(d4_vo), .aligned_o(d4_al),
    .phase_o(d4_ph), .align_err_o(d4_err));

  // ---------------- scenario table ----------------
  // Word index w counts wide words of the clean stream; w%128==0 is a FAW.
  // lock_w/unlock_w/relock_w: words whose completion changes aligned_o.
  typedef struct {
    int dut4;
    int junk;
    int gaps;
    int n_words;
    int lock_w;
    int unlock_w;
    int relock_w;
    int ph;
    int corr0;
    int corr1;
    int corr2;
    int inj0;
    int inj1;
  } scen_t;

  scen_t tbl[7];
  scen_t cur;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit cur_al;

  function automatic logic [63:0] gen_word(input int w);
    if (w == cur.corr0 || w == cur.corr1 || w == cur.corr2) return FAW ^ 64'h1;
    if (w == cur.inj0 || w == cur.inj1) return FAW;
    if (w % 128 == 0) return FAW;
    return {16'h1234, 16'(w), 32'(w * 7)};
  endfunction

  function automatic bit exp_on(input int w);
    return (w >= cur.lock_w && (cur.unlock_w < 0 || w < cur.unlock_w)) ||
           (cur.relock_w >= 0 && w >= cur.relock_w);
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_piece(input logic [63:0] word, input int p, input bit v,
                             input bit completes, input int w);
    logic [63:0] o_d;
    logic        o_v, o_al, o_err;
    bit          exp_v;
    logic [63:0] e;
    if (cur.dut4 != 0) begin
      d4_in = word[p*16 +: 16];
      d4_v  = v;
    end else begin
      d2_in = word[p*32 +: 32];
      d2_v  = v;
    end
    @(posedge clk);
    #1;
    o_d   = (cur.dut4 != 0) ? d4_out : d2_out;
    o_v   = (cur.dut4 != 0) ? d4_vo  : d2_vo;
    o_al  = (cur.dut4 != 0) ? d4_al  : d2_al;
    o_err = (cur.dut4 != 0) ? d4_err : d2_err;
    exp_v = v && completes && exp_on(w);
    if (exp_v) exp_q.push_back(word);
    check_val("tvalid_o", 64'(o_v), 64'(exp_v));
    if (o_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe got %h want none", o_d);
      end else begin
        e = exp_q.pop_front();
        check_val("tdata_o", o_d, e);
      end
    end else if (exp_v) begin
      void'(exp_q.pop_back());
    end
    if (v && completes) cur_al = exp_on(w);
    check_val("aligned_o", 64'(o_al), 64'(cur_al));
    check_val("align_err_o", 64'(o_err), 64'(v && completes && w == cur.unlock_w));
    if (cur.dut4 != 0) d4_v = 1'b0; else d2_v = 1'b0;
  endtask

  task automatic idle_cycle();
    drive_piece({$urandom, $urandom}, 0, 1'b0, 1'b0, -1);
  endtask

  // Reset is driven with valid FAW data present, so it must override an accept.
  task automatic do_reset();
    rst   = 1'b1;
    d2_v  = 1'b1;
    d2_in = 32'hF0F0_F0F0;
    d4_v  = 1'b1;
    d4_in = 16'hF0F0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    d2_v = 1'b0;
    d4_v = 1'b0;
    check_val("rst_tdata2", d2_out, 64'h0);
    check_val("rst_tvalid2", 64'(d2_vo), 64'h0);
    check_val("rst_aligned2", 64'(d2_al), 64'h0);
    check_val("rst_phase2", 64'(d2_ph), 64'h0);
    check_val("rst_err2", 64'(d2_err), 64'h0);
    check_val("rst_tdata4", d4_out, 64'h0);
    check_val("rst_tvalid4", 64'(d4_vo), 64'h0);
    check_val("rst_aligned4", 64'(d4_al), 64'h0);
    check_val("rst_phase4", 64'(d4_ph), 64'h0);
    check_val("rst_err4", 64'(d4_err), 64'h0);
  endtask

  task automatic run_scenario(input int idx);
    int r;
    logic [63:0] wv;
    cur    = tbl[idx];
    cur_al = 1'b0;
    exp_q.delete();
    r = (cur.dut4 != 0) ? 4 : 2;
    do_reset();
    for (int j = 0; j < cur.junk; j++) begin
      if (cur.gaps != 0 && $urandom_range(0, 1) == 1) idle_cycle();
      drive_piece(64'h0, 0, 1'b1, 1'b0, -1);
    end
    for (int w = 0; w < cur.n_words; w++) begin
      wv = gen_word(w);
      for (int p = 0; p < r; p++) begin
        if (cur.gaps != 0 && $urandom_range(0, 1) == 1) idle_cycle();
        drive_piece(wv, p, 1'b1, p == r - 1, w);
      end
    end
    check_val("phase_o", (cur.dut4 != 0) ? 64'(d4_ph) : 64'(d2_ph), 64'(cur.ph));
    check_val("exp_q_drained", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //           dut4 junk gaps n    lock unl  relk ph corr0 corr1 corr2 inj0 inj1
    tbl[0] = '{0, 0, 0,  520, 384,  -1,   -1, 1,  -1,  -1,  -1,  -1,  -1};
    tbl[1] = '{0, 1, 0,  520, 384,  -1,   -1, 0,  -1,  -1,  -1,  -1,  -1};
    tbl[2] = '{0, 0, 1,  520, 384,  -1,   -1, 1,  -1,  -1,  -1,  -1,  -1};
    tbl[3] = '{0, 0, 0, 1540, 384, 896, 1408, 1, 512, 768, 896,  -1,  -1};
    tbl[4] = '{0, 0, 0,  520, 384,  -1,   -1, 1,  -1,  -1,  -1, 200, 450};
    tbl[5] = '{1, 2, 0,  520, 384,  -1,   -1, 1,  -1,  -1,  -1,  -1,  -1};
    tbl[6] = '{1, 1, 1,  520, 384,  -1,   -1, 0,  -1,  -1,  -1,  -1,  -1};

    rst   = 1'b1;
    d2_in = '0;
    d2_v  = 1'b0;
    d4_in = '0;
    d4_v  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Each scenario begins with a reset while the previous one is still locked.
    for (int i = 0; i < 7; i++) run_scenario(i);

    // While locked, a long run with no valid input must change nothing.
    for (int k = 0; k < 20; k++) idle_cycle();

    do_reset();
    check_val("final_exp_q", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
